muldiv_seq: RTL and testbench

//  Multi-cycle, unsigned 32x32 multiply/divide unit for the ALU's M-path. Takes a

---
 rtl/muldiv_seq.sv | 134 +++++++++++++
 tb/tb_muldiv_seq.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// Sequential unsigned multiply/divide unit.
// Produces one result bit per clock using shift-add multiply or restoring divide.
// The latency is fixed at WIDTH cycles for every op and operand.
// Op select: 00=MULH, 10=MULL, 01=DIV, 11=REM.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             in_clk,
  input  logic             in_rst_n,
  input  logic             in_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       in_choice,
  output logic             o_valid,
  input  logic             in_ready,
  output logic [WIDTH-1:0] o_out,
  output logic             o_busy
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           stateQ, stateD;
  logic [CNT_W-1:0] cntQ, cntD;
  // hiQ is the upper product half or the partial remainder.
  // loQ is the multiplier or the dividend/quotient shift register.
  // opndQ is the multiplicand or the divisor.
  logic [WIDTH-1:0] hiQ, hiD;
  logic [WIDTH-1:0] loQ, loD;
  logic [WIDTH-1:0] opndQ, opndD;
  logic [1:0]       opQ, opD;
  logic [WIDTH-1:0] outQ, outD;

  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   remShift;
  logic             geDiv;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] hiStep, loStep;
  logic             resHi;

  // Datapath for one iteration, plus the FSM next-state and register loads.
  always_comb begin
    stateD = stateQ;
    cntD   = cntQ;
    hiD    = hiQ;
    loD    = loQ;
    opndD  = opndQ;
    opD    = opQ;
    outD   = outQ;

    addend   = loQ[0] ? opndQ : '0;
    sum      = {1'b0, hiQ} + {1'b0, addend};
    remShift = {hiQ, loQ[WIDTH-1]};
    geDiv    = (remShift >= {1'b0, opndQ});
    diff     = remShift[WIDTH-1:0] - opndQ;

    if (!opQ[0]) begin
      hiStep = sum[WIDTH:1];
      loStep = {sum[0], loQ[WIDTH-1:1]};
    end else if (geDiv) begin
      hiStep = diff;
      loStep = {loQ[WIDTH-2:0], 1'b1};
    end else begin
      hiStep = remShift[WIDTH-1:0];
      loStep = {loQ[WIDTH-2:0], 1'b0};
    end

    resHi = (opQ == 2'b00) || (opQ == 2'b11);

    case (stateQ)
      IDLE: begin
        if (in_valid) begin
          stateD = CALC;
          cntD   = '0;
          hiD    = '0;
          loD    = in_choice[0] ? a : b;
          opndD  = in_choice[0] ? b : a;
          opD    = in_choice;
        end
      end
      CALC: begin
        hiD  = hiStep;
        loD  = loStep;
        cntD = cntQ + CNT_W'(1);
        if (cntQ == CNT_W'(WIDTH - 1)) begin
          stateD = DONE;
          outD   = resHi ? hiStep : loStep;
        end
      end
      DONE: begin
        if (in_ready) begin
          stateD = IDLE;
        end
      end
      default: begin
        stateD = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any op in flight.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      stateQ <= IDLE;
      cntQ   <= '0;
      hiQ    <= '0;
      loQ    <= '0;
      opndQ  <= '0;
      opQ    <= '0;
      outQ   <= '0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
      hiQ    <= hiD;
      loQ    <= loD;
      opndQ  <= opndD;
      opQ    <= opD;
      outQ   <= outD;
    end
  end

  assign o_ready = (stateQ == IDLE);
  assign o_valid = (stateQ == DONE);
  assign o_busy  = (stateQ != IDLE);
  assign o_out   = outQ;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed testbench for muldiv_seq.
module tb_muldiv_seq;

  localparam int WIDTH = 32;
  localparam int MAX_WAIT = 100;

  logic             in_clk;
  logic             in_rst_n;
  logic             in_valid;
  logic             o_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       in_choice;
  logic             o_valid;
  logic             in_ready;
  logic [WIDTH-1:0] o_out;
  logic             o_busy;

  int testsRun;
  int testsFailed;

  muldiv_seq #(.WIDTH(WIDTH)) dut (
    .in_clk   (in_clk),
    .in_rst_n (in_rst_n),
    .in_valid (in_valid),
    .o_ready  (o_ready),
    .a        (a),
    .b        (b),
    .in_choice(in_choice),
    .o_valid  (o_valid),
    .in_ready (in_ready),
    .o_out    (o_out),
    .o_busy   (o_busy)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    in_clk = 1'b0;
    forever #5 in_clk = ~in_clk;
  end

  // Hard stop in case something hangs.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Issue one request and wait for the result while keeping in_ready low.
  // The operands are scrambled right after the accept edge. Returns the
  // number of edges from accept to o_valid, or MAX_WAIT+1 on timeout.
  task automatic issueAndWait(input logic [1:0] op, input logic [WIDTH-1:0] opA,
                              input logic [WIDTH-1:0] opB, output int cycles);
    @(negedge in_clk);
    in_valid  = 1'b1;
    in_choice = op;
    a         = opA;
    b         = opB;
    @(posedge in_clk);
    #1;
    in_valid  = 1'b0;
    a         = 32'hDEAD_BEEF;
    b         = 32'h0BAD_F00D;
    in_choice = ~op;
    cycles    = MAX_WAIT + 1;
    for (int i = 1; i <= MAX_WAIT; i++) begin
      @(posedge in_clk);
      #1;
      if (o_valid) begin
        cycles = i;
        break;
      end
    end
  endtask

  // Full transaction: issue, wait, capture the result, then hand it back.
  task automatic applyStimulus(input logic [1:0] op, input logic [WIDTH-1:0] opA,
                               input logic [WIDTH-1:0] opB,
                               output logic [WIDTH-1:0] result, output int cycles);
    issueAndWait(op, opA, opB, cycles);
    result   = o_out;
    in_ready = 1'b1;
    @(posedge in_clk);
    #1;
    in_ready = 1'b0;
  endtask

  task automatic test_reset();
    in_rst_n  = 1'b0;
    in_valid  = 1'b0;
    in_ready  = 1'b0;
    a         = '0;
    b         = '0;
    in_choice = 2'b00;
    #3;
    testsRun++;
    if (o_ready !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL reset_ready: got %b expected 1", o_ready);
    end
    testsRun++;
    if (o_valid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_valid: got %b expected 0", o_valid);
    end
    testsRun++;
    if (o_busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_busy: got %b expected 0", o_busy);
    end
    testsRun++;
    if (o_out !== 32'h0) begin
      testsFailed++;
      $display("[TB] FAIL reset_out: got %h expected 00000000", o_out);
    end
    @(negedge in_clk);
    in_rst_n = 1'b1;
  endtask

  task automatic test_mull_small();
    logic [WIDTH-1:0] res;
    int cyc;
    applyStimulus(2'b10, 32'd7, 32'd6, res, cyc);
    testsRun++;
    if (cyc !== 32) begin
      testsFailed++;
      $display("[TB] FAIL mull_latency: got %0d expected 32", cyc);
    end
    testsRun++;
    if (res !== 32'd42) begin
      testsFailed++;
      $display("[TB] FAIL mull_7x6: got %h expected 0000002a", res);
    end
  endtask

  task automatic test_mul_full();
    logic [WIDTH-1:0] res;
    int cyc;
    applyStimulus(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, cyc);
    testsRun++;
    if (res !== 32'hFFFF_FFFE) begin
      testsFailed++;
      $display("[TB] FAIL mulh_max: got %h expected fffffffe", res);
    end
    testsRun++;
    if (cyc !== 32) begin
      testsFailed++;
      $display("[TB] FAIL mulh_latency: got %0d expected 32", cyc);
    end
    applyStimulus(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, cyc);
    testsRun++;
    if (res !== 32'h0000_0001) begin
      testsFailed++;
      $display("[TB] FAIL mull_max: got %h expected 00000001", res);
    end
    applyStimulus(2'b00, 32'h0001_0000, 32'h0001_0000, res, cyc);
    testsRun++;
    if (res !== 32'h0000_0001) begin
      testsFailed++;
      $display("[TB] FAIL mulh_2p32: got %h expected 00000001", res);
    end
  endtask

  task automatic test_div();
    logic [WIDTH-1:0] res;
    int cyc;
    applyStimulus(2'b01, 32'd100, 32'd7, res, cyc);
    testsRun++;
    if (res !== 32'd14) begin
      testsFailed++;
      $display("[TB] FAIL div_100_7: got %h expected 0000000e", res);
    end
    testsRun++;
    if (cyc !== 32) begin
      testsFailed++;
      $display("[TB] FAIL div_latency: got %0d expected 32", cyc);
    end
    applyStimulus(2'b11, 32'd100, 32'd7, res, cyc);
    testsRun++;
    if (res !== 32'd2) begin
      testsFailed++;
      $display("[TB] FAIL rem_100_7: got %h expected 00000002", res);
    end
    applyStimulus(2'b01, 32'h8000_0000, 32'd1, res, cyc);
    testsRun++;
    if (res !== 32'h8000_0000) begin
      testsFailed++;
      $display("[TB] FAIL div_msb_1: got %h expected 80000000", res);
    end
    applyStimulus(2'b11, 32'h8000_0000, 32'd1, res, cyc);
    testsRun++;
    if (res !== 32'h0) begin
      testsFailed++;
      $display("[TB] FAIL rem_msb_1: got %h expected 00000000", res);
    end
    applyStimulus(2'b11, 32'hFFFF_FFFF, 32'h8000_0001, res, cyc);
    testsRun++;
    if (res !== 32'h7FFF_FFFE) begin
      testsFailed++;
      $display("[TB] FAIL rem_large: got %h expected 7ffffffe", res);
    end
  endtask

  task automatic test_div_zero();
    logic [WIDTH-1:0] res;
    int cyc;
    applyStimulus(2'b01, 32'h0000_1234, 32'h0, res, cyc);
    testsRun++;
    if (res !== 32'hFFFF_FFFF) begin
      testsFailed++;
      $display("[TB] FAIL div_by_zero: got %h expected ffffffff", res);
    end
    testsRun++;
    if (cyc !== 32) begin
      testsFailed++;
      $display("[TB] FAIL div_zero_latency: got %0d expected 32", cyc);
    end
    applyStimulus(2'b11, 32'h0000_1234, 32'h0, res, cyc);
    testsRun++;
    if (res !== 32'h0000_1234) begin
      testsFailed++;
      $display("[TB] FAIL rem_by_zero: got %h expected 00001234", res);
    end
    testsRun++;
    if (cyc !== 32) begin
      testsFailed++;
      $display("[TB] FAIL rem_zero_latency: got %0d expected 32", cyc);
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    int badCycles;
    issueAndWait(2'b10, 32'd3, 32'd5, cyc);
    testsRun++;
    if (cyc !== 32) begin
      testsFailed++;
      $display("[TB] FAIL bp_latency: got %0d expected 32", cyc);
    end
    badCycles = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      a        = 32'd1000 + 32'(i);
      if (o_valid !== 1'b1 || o_out !== 32'd15 || o_ready !== 1'b0 || o_busy !== 1'b1) begin
        badCycles++;
        $display("[TB] FAIL bp_hold cycle %0d: got valid=%b out=%h ready=%b busy=%b expected 1/0000000f/0/1",
                 i, o_valid, o_out, o_ready, o_busy);
      end
      @(posedge in_clk);
      #1;
    end
    testsRun++;
    if (badCycles !== 0) begin
      testsFailed++;
      $display("[TB] FAIL bp_stable: got %0d bad cycles expected 0", badCycles);
    end
    in_valid = 1'b0;
    in_ready = 1'b1;
    @(posedge in_clk);
    #1;
    in_ready = 1'b0;
    testsRun++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL bp_release: got ready=%b valid=%b busy=%b expected 1/0/0",
               o_ready, o_valid, o_busy);
    end
    testsRun++;
    if (o_out !== 32'd15) begin
      testsFailed++;
      $display("[TB] FAIL bp_idle_hold: got %h expected 0000000f", o_out);
    end
  endtask

  task automatic test_reset_midcalc();
    logic [WIDTH-1:0] res;
    int cyc;
    int sawValid;
    @(negedge in_clk);
    in_valid  = 1'b1;
    in_choice = 2'b01;
    a         = 32'd100;
    b         = 32'd7;
    @(posedge in_clk);
    #1;
    in_valid = 1'b0;
    repeat (16) @(posedge in_clk);
    #1;
    in_rst_n = 1'b0;
    #1;
    testsRun++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL midcalc_reset_ctl: got ready=%b valid=%b busy=%b expected 1/0/0",
               o_ready, o_valid, o_busy);
    end
    testsRun++;
    if (o_out !== 32'h0) begin
      testsFailed++;
      $display("[TB] FAIL midcalc_reset_out: got %h expected 00000000", o_out);
    end
    @(negedge in_clk);
    in_rst_n = 1'b1;
    sawValid = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge in_clk);
      #1;
      if (o_valid) sawValid++;
    end
    testsRun++;
    if (sawValid !== 0) begin
      testsFailed++;
      $display("[TB] FAIL stale_valid: got %0d valid cycles expected 0", sawValid);
    end
    applyStimulus(2'b11, 32'd100, 32'd7, res, cyc);
    testsRun++;
    if (res !== 32'd2 || cyc !== 32) begin
      testsFailed++;
      $display("[TB] FAIL post_reset_op: got res=%h lat=%0d expected 00000002/32", res, cyc);
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    testsRun    = 0;
    testsFailed = 0;
    test_reset();
    test_mull_small();
    test_mul_full();
    test_div();
    test_div_zero();
    test_backpressure();
    test_reset_midcalc();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
